// File: rtl/board_engine.sv
// board_engine: NxN sliding-merge board engine with LFSR tile spawning.
// Slides one line per cycle, then spawns a tile and refreshes won/lost.
module board_engine #(
    parameter int          N       = 4,
    parameter int          VW      = 4,
    parameter int          WIN_EXP = 11,
    parameter int          SCORE_W = 20,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               move_valid,
    input  logic [3:0]         move_dir,
    output logic               move_ready,
    input  logic               load_valid,
    input  logic [N*N*VW-1:0]  load_board,
    output logic [N*N*VW-1:0]  board,
    output logic [SCORE_W-1:0] score,
    output logic               done,
    output logic               changed,
    output logic               won,
    output logic               lost,
    output logic               busy
);
    localparam int                 NN   = N * N;
    localparam int                 CW   = $clog2(NN);
    localparam int                 LW   = $clog2(N);
    localparam logic [VW-1:0]      VMAX = '1;
    localparam logic [SCORE_W-1:0] SMAX = '1;
    localparam logic [15:0]        NN16 = 16'(NN);

    typedef enum logic [2:0] {
        S_INIT, S_SPAWN, S_IDLE, S_SLIDE, S_CHECK
    } state_t;

    typedef enum logic [1:0] {
        D_UP, D_DOWN, D_LEFT, D_RIGHT
    } dir_t;

    state_t               state_q, state_d;
    dir_t                 dir_q, dir_dec;
    logic                 dir_ok;
    logic [N*N*VW-1:0]    board_q;
    logic [SCORE_W-1:0]   score_q;
    logic [15:0]          lfsr_q, lfsr_nx;
    logic                 done_q, changed_q, won_q, lost_q;
    logic [LW-1:0]        line_q;
    logic                 last_line;
    logic [CW-1:0]        scan_q;
    logic                 scan_last;
    logic [1:0]           spawn_left_q;
    logic                 init_run_q;

    // cell index of position j (0 = destination edge) within line i
    function automatic int cell_at(dir_t d, int i, int j);
        int r;
        r = 0;
        unique case (d)
            D_UP:    r = j * N + i;
            D_DOWN:  r = (N - 1 - j) * N + i;
            D_LEFT:  r = i * N + j;
            D_RIGHT: r = i * N + (N - 1 - j);
        endcase
        return r;
    endfunction

    function automatic logic [SCORE_W-1:0] sadd(
        logic [SCORE_W-1:0] a,
        logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? SMAX : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] pw(int e);
        logic [SCORE_W-1:0] one;
        one = 1;
        return (e >= SCORE_W) ? SMAX : (one << e);
    endfunction

    // decode a one-hot direction request
    always_comb begin
        dir_ok  = (move_dir != 4'd0) &&
                  ((move_dir & (move_dir - 4'd1)) == 4'd0);
        dir_dec = D_LEFT;
        if (dir_ok) begin
            unique case (1'b1)
                move_dir[3]: dir_dec = D_UP;
                move_dir[2]: dir_dec = D_DOWN;
                move_dir[1]: dir_dec = D_LEFT;
                move_dir[0]: dir_dec = D_RIGHT;
            endcase
        end
    end

    logic [N*VW-1:0]    lin, lout;
    logic [VW-1:0]      pend;
    logic               pend_v;
    int                 k, src;
    logic [SCORE_W-1:0] gain;
    logic [N*N*VW-1:0]  slid;
    logic               line_chg;

    // compact and merge the current line toward its destination edge
    always_comb begin
        lin      = '0;
        lout     = '0;
        pend     = '0;
        pend_v   = 1'b0;
        k        = 0;
        src      = 0;
        gain     = '0;
        slid     = board_q;
        line_chg = 1'b0;
        for (int j = 0; j < N; j++) begin
            src = cell_at(dir_q, int'(line_q), j);
            lin[j*VW +: VW] = board_q[src*VW +: VW];
        end
        for (int j = 0; j < N; j++) begin
            if (lin[j*VW +: VW] != '0) begin
                if (pend_v && pend == lin[j*VW +: VW]) begin
                    lout[k*VW +: VW] = (pend == VMAX) ? VMAX : pend + 1'b1;
                    gain   = sadd(gain, pw(int'(pend) + 1));
                    k      = k + 1;
                    pend_v = 1'b0;
                end else begin
                    if (pend_v) begin
                        lout[k*VW +: VW] = pend;
                        k = k + 1;
                    end
                    pend   = lin[j*VW +: VW];
                    pend_v = 1'b1;
                end
            end
        end
        if (pend_v) begin
            lout[k*VW +: VW] = pend;
        end
        for (int j = 0; j < N; j++) begin
            src = cell_at(dir_q, int'(line_q), j);
            slid[src*VW +: VW] = lout[j*VW +: VW];
        end
        line_chg = (lout != lin);
    end

    logic [15:0]   pos16;
    int            pos;
    logic          spawn_hit;
    logic [VW-1:0] spawn_val;

    // spawn scan position, value and next LFSR state
    always_comb begin
        pos16     = ((lfsr_q % NN16) + 16'(scan_q)) % NN16;
        pos       = int'(pos16);
        spawn_hit = (board_q[pos*VW +: VW] == '0);
        scan_last = (scan_q == CW'(NN - 1));
        spawn_val = (lfsr_q[3:0] == 4'd0) ? VW'(2) : VW'(1);
        lfsr_nx   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]};
        last_line = (line_q == LW'(N - 1));
    end

    logic          any_empty, any_pair, any_win;
    logic [VW-1:0] cv;
    int            rn, dn;

    // board status: empties, mergeable neighbours, winning tile
    always_comb begin
        any_empty = 1'b0;
        any_pair  = 1'b0;
        any_win   = 1'b0;
        cv        = '0;
        rn        = 0;
        dn        = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                cv = board_q[(r*N+c)*VW +: VW];
                rn = (c < N - 1) ? r * N + c + 1 : r * N + c;
                dn = (r < N - 1) ? (r + 1) * N + c : r * N + c;
                if (cv == '0) any_empty = 1'b1;
                if (int'(cv) >= WIN_EXP) any_win = 1'b1;
                if (c < N - 1 && cv == board_q[rn*VW +: VW])
                    any_pair = 1'b1;
                if (r < N - 1 && cv == board_q[dn*VW +: VW])
                    any_pair = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  state_d = S_SPAWN;
            S_IDLE: begin
                if (load_valid)
                    state_d = S_CHECK;
                else if (move_valid && dir_ok)
                    state_d = S_SLIDE;
            end
            S_SLIDE: begin
                if (last_line)
                    state_d = (changed_q || line_chg) ? S_SPAWN : S_IDLE;
            end
            S_SPAWN: begin
                if ((spawn_hit || scan_last) && spawn_left_q == 2'd1)
                    state_d = init_run_q ? S_IDLE : S_CHECK;
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // board, score, LFSR and status registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            board_q      <= '0;
            score_q      <= '0;
            lfsr_q       <= SEED;
            done_q       <= 1'b0;
            changed_q    <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            dir_q        <= D_LEFT;
            line_q       <= '0;
            scan_q       <= '0;
            spawn_left_q <= '0;
            init_run_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    spawn_left_q <= 2'd2;
                    init_run_q   <= 1'b1;
                    scan_q       <= '0;
                end
                S_IDLE: begin
                    if (load_valid) begin
                        board_q   <= load_board;
                        score_q   <= '0;
                        won_q     <= 1'b0;
                        changed_q <= 1'b1;
                    end else if (move_valid) begin
                        changed_q <= 1'b0;
                        line_q    <= '0;
                        if (dir_ok) dir_q  <= dir_dec;
                        else        done_q <= 1'b1;
                    end
                end
                S_SLIDE: begin
                    board_q <= slid;
                    score_q <= sadd(score_q, gain);
                    line_q  <= line_q + 1'b1;
                    if (line_chg) changed_q <= 1'b1;
                    if (last_line) begin
                        if (!(changed_q || line_chg)) done_q <= 1'b1;
                        spawn_left_q <= 2'd1;
                        init_run_q   <= 1'b0;
                        scan_q       <= '0;
                    end
                end
                S_SPAWN: begin
                    if (spawn_hit || scan_last) begin
                        if (spawn_hit) board_q[pos*VW +: VW] <= spawn_val;
                        lfsr_q       <= lfsr_nx;
                        scan_q       <= '0;
                        spawn_left_q <= spawn_left_q - 2'd1;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    won_q  <= won_q | any_win;
                    lost_q <= !any_empty && !any_pair;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign move_ready = (state_q == S_IDLE);
    assign busy       = ~move_ready;
    assign board      = board_q;
    assign score      = score_q;
    assign done       = done_q;
    assign changed    = changed_q;
    assign won        = won_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: randomized moves/loads against a queue-based board model.
// Directed cases pin merge rules, win, loss, no-change timing and reset.
module tb_board_engine;
    localparam int N     = 4;
    localparam int VW    = 4;
    localparam int NN    = N * N;
    localparam int WIN   = 11;
    localparam int SW    = 20;
    localparam int VMAXI = (1 << VW) - 1;
    localparam int SMAXI = (1 << SW) - 1;

    logic              clock = 1'b0;
    logic              resetn = 1'b1;
    logic              move_valid = 1'b0;
    logic [3:0]        move_dir = 4'd0;
    logic              move_ready;
    logic              load_valid = 1'b0;
    logic [NN*VW-1:0]  load_board = '0;
    logic [NN*VW-1:0]  board;
    logic [SW-1:0]     score;
    logic              done, changed, won, lost, busy;

    always #5 clock = ~clock;

    board_engine dut (
        .clock(clock), .resetn(resetn),
        .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready),
        .load_valid(load_valid), .load_board(load_board),
        .board(board), .score(score), .done(done),
        .changed(changed), .won(won), .lost(lost), .busy(busy)
    );

    int          total = 0;
    int          bad = 0;
    int          mb[NN];
    int          mscore;
    logic [15:0] mlfsr;
    bit          mwon, mlost;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    function automatic logic [63:0] pack_model();
        logic [63:0] b;
        b = '0;
        for (int p = 0; p < NN; p++) b[p*VW +: VW] = 4'(mb[p]);
        return b;
    endfunction

    function automatic bit model_lost();
        for (int p = 0; p < NN; p++) if (mb[p] == 0) return 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (c < N - 1 && mb[r*N+c] == mb[r*N+c+1]) return 0;
                if (r < N - 1 && mb[r*N+c] == mb[(r+1)*N+c]) return 0;
            end
        return 1;
    endfunction

    function automatic bit model_win();
        for (int p = 0; p < NN; p++) if (mb[p] >= WIN) return 1;
        return 0;
    endfunction

    function automatic int dcell(input int r, input int c);
        return int'(board[(r*N+c)*VW +: VW]);
    endfunction

    // place one tile; d = number of occupied cells skipped
    task automatic model_spawn(output int d);
        int base, p;
        base = int'(mlfsr) % NN;
        d = NN - 1;
        for (int s = 0; s < NN; s++) begin
            p = (base + s) % NN;
            if (mb[p] == 0) begin
                mb[p] = (mlfsr[3:0] == 4'd0) ? 2 : 1;
                d = s;
                break;
            end
        end
        mlfsr = lstep(mlfsr);
    endtask

    // whole-board slide: gather each line, merge pairs front to back
    task automatic model_move(input logic [3:0] dir, output bit chg);
        int nb[NN];
        int idx[N];
        int q[$];
        int o[$];
        int v;
        chg = 0;
        for (int i = 0; i < N; i++) begin
            q.delete();
            o.delete();
            for (int j = 0; j < N; j++) begin
                if (dir == 4'd8)      idx[j] = j * N + i;
                else if (dir == 4'd4) idx[j] = (N - 1 - j) * N + i;
                else if (dir == 4'd2) idx[j] = i * N + j;
                else                  idx[j] = i * N + (N - 1 - j);
                if (mb[idx[j]] != 0) q.push_back(mb[idx[j]]);
            end
            while (q.size() > 0) begin
                v = q.pop_front();
                if (q.size() > 0 && q[0] == v) begin
                    void'(q.pop_front());
                    o.push_back(v == VMAXI ? VMAXI : v + 1);
                    mscore += (1 << (v + 1));
                    if (mscore > SMAXI) mscore = SMAXI;
                end else begin
                    o.push_back(v);
                end
            end
            for (int j = 0; j < N; j++) begin
                v = (j < o.size()) ? o[j] : 0;
                if (v != mb[idx[j]]) chg = 1;
                nb[idx[j]] = v;
            end
        end
        for (int p = 0; p < NN; p++) mb[p] = nb[p];
    endtask

    // wait for done and compare every output against the model
    task automatic finish_op(input string nm, input int lat_exp,
                             input bit chg_exp);
        int lat;
        lat = 0;
        if (lat_exp > 0) chk({nm, ":busy"}, busy, 1);
        while (done !== 1'b1 && lat < 400) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({nm, ":latency"}, lat, lat_exp);
        chk({nm, ":changed"}, changed, chg_exp);
        chk({nm, ":board"}, board, pack_model());
        chk({nm, ":score"}, score, mscore);
        chk({nm, ":won"}, won, mwon);
        chk({nm, ":lost"}, lost, mlost);
        chk({nm, ":ready"}, move_ready, 1);
        @(posedge clock); #1;
        chk({nm, ":pulse"}, done, 0);
    endtask

    task automatic do_load(input string nm);
        for (int p = 0; p < NN; p++) load_board[p*VW +: VW] = 4'(mb[p]);
        load_valid = 1'b1;
        @(posedge clock); #1;
        load_valid = 1'b0;
        mscore = 0;
        mwon   = model_win();
        mlost  = model_lost();
        finish_op(nm, 1, 1);
    endtask

    task automatic do_move(input string nm, input logic [3:0] dir);
        bit chg;
        int d, lat;
        chk({nm, ":ready_in"}, move_ready, 1);
        move_dir   = dir;
        move_valid = 1'b1;
        @(posedge clock); #1;
        move_valid = 1'b0;
        chg = 0;
        lat = 0;
        if (dir inside {4'd1, 4'd2, 4'd4, 4'd8}) begin
            model_move(dir, chg);
            lat = N;
            if (chg) begin
                model_spawn(d);
                mwon  = mwon | model_win();
                mlost = model_lost();
                lat   = N + d + 2;
            end
        end
        finish_op(nm, lat, chg);
    endtask

    task automatic reset_init(input string nm);
        int d, n, dn;
        resetn     = 1'b0;
        move_valid = 1'b0;
        load_valid = 1'b0;
        #1;
        chk({nm, ":rst_board"}, board, 0);
        chk({nm, ":rst_score"}, score, 0);
        chk({nm, ":rst_done"}, done, 0);
        @(negedge clock);
        resetn = 1'b1;
        for (int p = 0; p < NN; p++) mb[p] = 0;
        mscore = 0;
        mlfsr  = 16'hACE1;
        mwon   = 0;
        mlost  = 0;
        model_spawn(d);
        model_spawn(d);
        n  = 0;
        dn = 0;
        while (move_ready !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            if (done) dn++;
            n++;
        end
        chk({nm, ":init_ready"}, move_ready, 1);
        chk({nm, ":init_nodone"}, dn, 0);
        chk({nm, ":init_board"}, board, pack_model());
        chk({nm, ":init_score"}, score, 0);
        chk({nm, ":init_won"}, won, 0);
        chk({nm, ":init_lost"}, lost, 0);
    endtask

    function automatic void clear_model();
        for (int p = 0; p < NN; p++) mb[p] = 0;
    endfunction

    initial begin
        int nz, r;
        logic [63:0] img;
        logic [3:0] dir;
        bit hi;
        #2;
        reset_init("reset0");
        chk("init_literal", board, 64'h12);

        clear_model();
        mb[0] = 1; mb[1] = 1; mb[2] = 2; mb[3] = 2;
        do_load("load_1122");
        do_move("left_1122", 4'd2);
        chk("l1122_c00", dcell(0, 0), 2);
        chk("l1122_c01", dcell(0, 1), 3);
        chk("l1122_score", score, 12);
        nz = 0;
        for (int p = 0; p < NN; p++) if (board[p*VW +: VW] != 0) nz++;
        chk("l1122_tiles", nz, 3);

        clear_model();
        mb[0] = 2; mb[1] = 1; mb[2] = 1;
        do_load("load_2110");
        do_move("left_2110", 4'd2);
        chk("l2110_c00", dcell(0, 0), 2);
        chk("l2110_c01", dcell(0, 1), 2);
        chk("l2110_score", score, 4);

        for (int p = 0; p < NN; p++) mb[p] = (((p / N) + (p % N)) % 2) + 1;
        img = pack_model();
        do_load("load_checker");
        chk("checker_lost", lost, 1);
        do_move("up_checker", 4'd8);
        chk("checker_same", board, img);

        clear_model();
        mb[0] = 10; mb[1] = 10;
        do_load("load_win");
        do_move("left_win", 4'd2);
        chk("win_c00", dcell(0, 0), 11);
        chk("win_flag", won, 1);
        chk("win_score", score, 2048);

        clear_model();
        mb[0] = 1; mb[1] = 2; mb[2] = 3; mb[3] = 4;
        do_load("load_1234");
        do_move("left_1234", 4'd2);
        do_move("down_after", 4'd4);

        clear_model();
        mb[0] = 15; mb[1] = 15;
        do_load("load_sat");
        do_move("left_sat", 4'd2);
        chk("sat_c00", dcell(0, 0), 15);
        chk("sat_score", score, 65536);

        do_move("bad_dir", 4'b0101);
        do_move("zero_dir", 4'b0000);

        clear_model();
        mb[0] = 1; mb[1] = 1; mb[2] = 2; mb[3] = 2;
        do_load("load_rst");
        move_dir   = 4'd2;
        move_valid = 1'b1;
        @(posedge clock); #1;
        move_valid = 1'b0;
        @(posedge clock); #1;
        chk("midslide_score", score, 12);
        #1;
        reset_init("reset_mid");
        chk("reinit_literal", board, 64'h12);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi = ($urandom_range(0, 5) == 0);
                for (int p = 0; p < NN; p++) begin
                    r = $urandom_range(0, 9);
                    mb[p] = (r < 4) ? 0 : r - 3;
                    if (hi && r >= 8) mb[p] = $urandom_range(9, 11);
                end
                do_load("rnd_load");
            end else begin
                if ($urandom_range(0, 9) == 0)
                    dir = 4'($urandom_range(0, 15));
                else
                    dir = 4'(1 << $urandom_range(0, 3));
                do_move("rnd_move", dir);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
